block_collision_scanner: RTL and testbench
==========================================

Name: block_collision_scanner

Overview:
- Upstream of the block-alive register stage. Once per frame, tests the ball bounding box against every still-alive brick in the grid.
- Each block test is a sequential scan, one brick per clock.
- Result: at most one single-cycle collide pulse per frame, which the alive stage uses to clear that brick's flag.
- Also issues flip_x/flip_y bounce requests to the ball-motion logic and a done strobe.

Parameters:
- NUM_BLOCKS, 10, number of bricks; equals COLS*ROWS.
- COLS, 5, bricks per row; brick index k sits at column k mod COLS, row k div COLS.
- X_ORG, 40, x of column-0 left edge (pixels).
- Y_ORG, 40, y of row-0 top edge.
- BLK_W, 100, brick width.
- BLK_H, 20, brick height.
- GAP, 10, spacing between bricks, both axes.
- BALL_SZ, 8, ball square side.
- CW, 11, coordinate width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse; start a scan.
- ball_x  in  CW  ball top-left x, sampled on an accepted frame_tick.
- ball_y  in  CW  ball top-left y, sampled on an accepted frame_tick.
- alive  in  NUM_BLOCKS  per-brick alive flags from the alive stage; read live during the scan.
- collide  out  NUM_BLOCKS  one-hot, one-cycle hit pulse (bit k = brick k).
- flip_x  out  1  one-cycle request to negate ball x velocity.
- flip_y  out  1  one-cycle request to negate ball y velocity.
- busy  out  1  high in SCAN and REPORT.
- done  out  1  one-cycle scan-complete strobe.

Behaviour:
- Reset state: rst low forces the FSM to IDLE asynchronously and clears all outputs to 0: collide=0, flip_x=0, flip_y=0, busy=0, done=0. It also clears the index, column and row counters and the hit registers.
- This applies mid-scan too: no pulse is emitted for a scan that was interrupted by reset.
- FSM states are IDLE, SCAN and REPORT.
- IDLE: on frame_tick=1, latch ball_x/ball_y, set idx=0, col=0, row=0, go to SCAN. frame_tick is ignored while busy=1.
- SCAN: one brick per cycle.
  - Brick geometry: x0 = X_ORG + col*(BLK_W+GAP), y0 = Y_ORG + row*(BLK_H+GAP).
  - Generate x0/y0 with incremental adders: add the pitch when col advances; reset col to 0 and add the row pitch when col reaches COLS-1. No multipliers or dividers.
  - Overlap test uses strict inequalities, so edge-touching is not a hit: bx < x0+BLK_W, bx+BALL_SZ > x0, by < y0+BLK_H, by+BALL_SZ > y0.
  - Evaluate all sums at CW+1 bits, unsigned.
  - Hit = overlap AND alive[idx]. On a hit, record idx and go to REPORT immediately; first hit in index order wins and the remaining bricks are not tested.
  - With no hit, after idx=NUM_BLOCKS-1 go to REPORT with no hit recorded.
- Bounce axis on a hit:
  - px = min(bx+BALL_SZ-x0, x0+BLK_W-bx); py = min(by+BALL_SZ-y0, y0+BLK_H-by).
  - px < py gives flip_x=1; otherwise flip_y=1. A tie gives flip_y.
  - Exactly one flip is set per hit.
- REPORT lasts exactly one cycle, then returns to IDLE.
  - done=1.
  - collide = one-hot of the recorded idx, or all-zero if there was no hit.
  - flip_x/flip_y as computed above.
  - All of these outputs are registered.
- Latency, with the accepted tick at cycle 0: a hit at index k reports at cycle k+2. A miss reports at cycle NUM_BLOCKS+1. The next tick can be accepted in the cycle after REPORT.
- A brick whose alive bit is 0 is never reported, even if geometry overlaps.
- Ball coordinates off-screen or past the grid simply produce a miss; no wrap handling is needed.

Decomposition:
- Shared package brick_pkg holds:
  - NUM_BLOCKS, COLS, X_ORG, Y_ORG, BLK_W, BLK_H, GAP, BALL_SZ, CW;
  - derived X_PITCH=BLK_W+GAP and Y_PITCH=BLK_H+GAP;
  - the FSM state enum.
  The alive stage uses the same NUM_BLOCKS.
- One combinational sub-module, rect_overlap: inputs bx, by, x0, y0; outputs hit, use_flip_x.
- The FSM, geometry counters and output registers stay in block_collision_scanner.

Test Plan:
- 1. Bottom-area hit: all alive, ball (200,75), tick at cycle 0 → cycle 8: done=1, collide=10'b0001000000 (brick 6), flip_y=1, flip_x=0. px=50, py=13.
- 2. Side hit: ball (136,45) → cycle 2: collide bit 0, flip_x=1. px=4, py=13.
- 3. Miss and edge cases:
  - Ball (10,300) → cycle 11: done=1, collide=0, no flips.
  - Ball (140,45), touching brick 0's right edge → same, no hit.
- 4. Dead brick: as scenario 1 but alive[6]=0 → cycle 11: done=1, collide=0.
- 5. Tick while busy and reset mid-scan:
  - Second tick at cycle 3 of a miss scan → ignored; exactly one done at cycle 11.
  - Separately, rst low at cycle 4 → all outputs 0, busy=0, no collide ever issued.
  - After rst release, a new tick scans normally.
- 6. Back-to-back frames: ticks at cycles 0 and 12 with scenario-1 coordinates, alive[6] deasserted by the alive stage after the first pulse → first scan hits brick 6; second scan misses, done at cycle 23.

Source files
------------

// File: rtl/brick_pkg.sv
// brick_pkg: brick grid geometry, ball size and scanner state encoding
package brick_pkg;
  localparam int NUM_BLOCKS = 10;
  localparam int COLS = 5;
  localparam int ROWS = NUM_BLOCKS / COLS;
  localparam int X_ORG = 40;
  localparam int Y_ORG = 40;
  localparam int BLK_W = 100;
  localparam int BLK_H = 20;
  localparam int GAP = 10;
  localparam int BALL_SZ = 8;
  localparam int CW = 11;
  localparam int X_PITCH = BLK_W + GAP;
  localparam int Y_PITCH = BLK_H + GAP;
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = ROWS > 1 ? $clog2(ROWS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
endpackage

// File: rtl/block_collision_scanner_if.sv
// block_collision_scanner_if: frame request in, collision/bounce report out
interface block_collision_scanner_if;
  import brick_pkg::*;
  logic frame_tick;
  logic [CW-1:0] ball_x;
  logic [CW-1:0] ball_y;
  logic [NUM_BLOCKS-1:0] alive;
  logic [NUM_BLOCKS-1:0] collide;
  logic flip_x;
  logic flip_y;
  logic busy;
  logic done;
  modport master(output frame_tick, ball_x, ball_y, alive, input collide, flip_x, flip_y, busy, done);
  modport slave(input frame_tick, ball_x, ball_y, alive, output collide, flip_x, flip_y, busy, done);
endinterface

// File: rtl/rect_overlap.sv
// rect_overlap: strict ball/brick overlap test and shallower-penetration bounce axis
module rect_overlap
  import brick_pkg::*;
(
  input  logic [CW-1:0] bx,
  input  logic [CW-1:0] by,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  output logic          hit,
  output logic          use_flip_x
);
  localparam logic [CW:0] SZ = (CW+1)'(BALL_SZ);
  localparam logic [CW:0] W = (CW+1)'(BLK_W);
  localparam logic [CW:0] H = (CW+1)'(BLK_H);
  logic [CW:0] bl, br, bt, bb, xl, xr, yt, yb, px, py;
  assign bl = {1'b0, bx};
  assign bt = {1'b0, by};
  assign xl = {1'b0, x0};
  assign yt = {1'b0, y0};
  assign br = bl + SZ;
  assign bb = bt + SZ;
  assign xr = xl + W;
  assign yb = yt + H;
  assign hit = bl < xr && br > xl && bt < yb && bb > yt;
  // penetration depths only meaningful when hit is set
  assign px = (br - xl) < (xr - bl) ? br - xl : xr - bl;
  assign py = (bb - yt) < (yb - bt) ? bb - yt : yb - bt;
  assign use_flip_x = px < py;
endmodule

// File: rtl/block_collision_scanner.sv
// block_collision_scanner: per-frame sequential ball-vs-brick scan, first live hit wins
module block_collision_scanner
  import brick_pkg::*;
(
  input logic clk,
  input logic rst,
  block_collision_scanner_if.slave bus
);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CW-1:0] bx, by, x0, y0;
  logic ov, use_fx, hit, last;
  rect_overlap u_ov (.bx(bx), .by(by), .x0(x0), .y0(y0), .hit(ov), .use_flip_x(use_fx));
  assign hit = state == SCAN && ov && bus.alive[idx];
  assign last = idx == IW'(NUM_BLOCKS - 1);
  assign bus.busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (bus.frame_tick ? SCAN : IDLE) :
               state == SCAN ? ((hit || last) ? REPORT : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      col <= '0;
      row <= '0;
      bx <= '0;
      by <= '0;
      x0 <= '0;
      y0 <= '0;
      bus.collide <= '0;
      bus.flip_x <= 1'b0;
      bus.flip_y <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_nx;
      bus.done <= state == SCAN && state_nx == REPORT;
      bus.collide <= hit ? {{(NUM_BLOCKS-1){1'b0}}, 1'b1} << idx : '0;
      bus.flip_x <= hit && use_fx;
      bus.flip_y <= hit && !use_fx;
      if (state == IDLE && bus.frame_tick) begin
        bx <= bus.ball_x;
        by <= bus.ball_y;
        idx <= '0;
        col <= '0;
        row <= '0;
        x0 <= CW'(X_ORG);
        y0 <= CW'(Y_ORG);
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        // brick origin tracked incrementally along the row, wrapping to the next row
        col <= col == COL_W'(COLS - 1) ? '0 : col + 1'b1;
        row <= col == COL_W'(COLS - 1) ? row + 1'b1 : row;
        x0 <= col == COL_W'(COLS - 1) ? CW'(X_ORG) : x0 + CW'(X_PITCH);
        y0 <= col == COL_W'(COLS - 1) ? y0 + CW'(Y_PITCH) : y0;
      end
    end
  end
endmodule

// File: tb/tb_block_collision_scanner.sv
// tb_block_collision_scanner: random + directed frames against a geometric reference model
module tb_block_collision_scanner;
  import brick_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  int tick_cyc = -100;
  int rep_cyc = -100;
  logic [NUM_BLOCKS-1:0] exp_col = '0;
  bit exp_fx = 0;
  bit exp_fy = 0;
  block_collision_scanner_if bus ();
  block_collision_scanner dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  function automatic void model(input int bx, input int by, input logic [NUM_BLOCKS-1:0] a,
                                output int k, output bit fx);
    k = -1;
    fx = 0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      int x0, y0, px, py;
      x0 = X_ORG + (i % COLS) * (BLK_W + GAP);
      y0 = Y_ORG + (i / COLS) * (BLK_H + GAP);
      if (k < 0 && a[i] && bx < x0 + BLK_W && bx + BALL_SZ > x0 && by < y0 + BLK_H && by + BALL_SZ > y0) begin
        px = (bx + BALL_SZ - x0) < (x0 + BLK_W - bx) ? bx + BALL_SZ - x0 : x0 + BLK_W - bx;
        py = (by + BALL_SZ - y0) < (y0 + BLK_H - by) ? by + BALL_SZ - y0 : y0 + BLK_H - by;
        k = i;
        fx = px < py;
      end
    end
  endfunction
  // every cycle: outputs follow the scheduled report derived from the model
  always @(negedge clk) begin
    bit d;
    d = cyc == rep_cyc;
    chk("done", 32'(bus.done), 32'(d));
    chk("busy", 32'(bus.busy), 32'(cyc > tick_cyc && cyc <= rep_cyc));
    chk("collide", 32'(bus.collide), d ? 32'(exp_col) : 32'd0);
    chk("flip_x", 32'(bus.flip_x), 32'(d && exp_fx));
    chk("flip_y", 32'(bus.flip_y), 32'(d && exp_fy));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input int x, input int y, input logic [NUM_BLOCKS-1:0] a);
    int k;
    bit fx;
    if (rst && !(cyc > tick_cyc && cyc <= rep_cyc)) begin
      bus.alive = a;
      model(x, y, a, k, fx);
      tick_cyc = cyc;
      rep_cyc = cyc + (k < 0 ? NUM_BLOCKS + 1 : k + 2);
      exp_col = k < 0 ? '0 : NUM_BLOCKS'(1) << k;
      exp_fx = k >= 0 && fx;
      exp_fy = k >= 0 && !fx;
    end
    bus.ball_x = CW'(x);
    bus.ball_y = CW'(y);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask
  task automatic lit_at(input int c, input string n, input logic [NUM_BLOCKS-1:0] col, input bit fx, input bit fy);
    while (cyc < c) step();
    @(negedge clk);
    chk({n, "_done"}, 32'(bus.done), 32'd1);
    chk({n, "_collide"}, 32'(bus.collide), 32'(col));
    chk({n, "_fx"}, 32'(bus.flip_x), 32'(fx));
    chk({n, "_fy"}, 32'(bus.flip_y), 32'(fy));
    step();
  endtask
  initial begin
    int k, t;
    bit fx;
    bus.frame_tick = 1'b0;
    bus.ball_x = '0;
    bus.ball_y = '0;
    bus.alive = '1;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    model(200, 75, '1, k, fx);
    chk("model_s1", 32'(k), 32'd6);
    chk("model_s1_fx", 32'(fx), 32'd0);
    model(136, 45, '1, k, fx);
    chk("model_s2", 32'(k), 32'd0);
    chk("model_s2_fx", 32'(fx), 32'd1);
    model(10, 300, '1, k, fx);
    chk("model_miss", 32'(k), 32'hffffffff);
    model(140, 45, '1, k, fx);
    chk("model_edge", 32'(k), 32'hffffffff);
    model(200, 75, 10'h3bf, k, fx);
    chk("model_dead", 32'(k), 32'hffffffff);
    t = cyc;
    tick(200, 75, '1);
    lit_at(t + 8, "s1", 10'b0001000000, 1'b0, 1'b1);
    t = cyc;
    tick(136, 45, '1);
    lit_at(t + 2, "s2", 10'b1, 1'b1, 1'b0);
    t = cyc;
    tick(10, 300, '1);
    lit_at(t + 11, "s3", '0, 1'b0, 1'b0);
    t = cyc;
    tick(140, 45, '1);
    lit_at(t + 11, "edge", '0, 1'b0, 1'b0);
    t = cyc;
    tick(200, 75, 10'h3bf);
    lit_at(t + 11, "dead", '0, 1'b0, 1'b0);
    t = cyc;
    tick(10, 300, '1);
    repeat (2) step();
    tick(200, 75, '1);
    lit_at(t + 11, "busy_tick", '0, 1'b0, 1'b0);
    repeat (3) step();
    tick(200, 75, '1);
    repeat (3) step();
    rst = 1'b0;
    tick_cyc = -100;
    rep_cyc = -100;
    repeat (3) step();
    rst = 1'b1;
    repeat (12) step();
    t = cyc;
    tick(200, 75, '1);
    lit_at(t + 8, "b2b_a", 10'b0001000000, 1'b0, 1'b1);
    bus.alive = 10'h3bf;
    while (cyc < t + 12) step();
    tick(200, 75, 10'h3bf);
    lit_at(t + 23, "b2b_b", '0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      tick(int'($urandom_range(0, 560)), int'($urandom_range(20, 110)),
           (i % 3 == 0) ? '1 : NUM_BLOCKS'($urandom));
      repeat ($urandom_range(0, 13)) step();
    end
    repeat (14) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
